qspi_host_ctrl: RTL and testbench
=================================

Name: qspi_host_ctrl

Overview:
Host-side SPI/QSPI master that drives the SPI device port of top_core (spi_sclk, spi_cs, spi_sdi0..3) and captures its spi_sdo0..3. It takes one transaction request per handshake and serializes it as command / address / dummy / data phases, with the lane count selected per request. It is the upstream stage of the SPI slave. Both the bench and the FPGA bring-up wrapper use it in place of hand-coded SPI tasks.

Parameters:
CLK_DIV, 2, clk_i cycles per sclk half-period; legal range 1..255.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  high only in IDLE
req_quad_i  in  1  0 = 1 lane (sdo[0]/sdi[0]), 1 = 4 lanes for all phases
req_cmd_i  in  8  command byte
req_addr_en_i  in  1  address phase present
req_addr_i  in  32  address
req_dummy_i  in  5  dummy sclk cycles (0 = none)
req_wr_i  in  1  1 = data phase drives, 0 = data phase samples
req_len_i  in  6  data bits (0..32)
req_wdata_i  in  32  write data, right-justified
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  32  read data, right-justified
busy_o  out  1  high whenever not IDLE
spi_sclk_o  out  1  serial clock, SPI mode 0
spi_csn_o  out  1  chip select, active low
spi_sdo_o  out  4  host-to-device lanes (to spi_sdi0..3)
spi_sdo_oe_o  out  4  lane output enables
spi_sdi_i  in  4  device-to-host lanes (from spi_sdo0..3)

Behaviour:
- Reset values: req_ready_o=1, busy_o=0, rsp_valid_o=0, rsp_rdata_o=0, spi_sclk_o=0, spi_csn_o=1, spi_sdo_o=0, spi_sdo_oe_o=0. An asynchronous reset mid-transfer aborts immediately to these values. No rsp pulse is issued for the aborted transfer.
- Acceptance: a request is accepted on a clk_i edge with req_valid_i & req_ready_o. All req_* inputs are registered at acceptance. Requests arriving while busy are ignored.
- Length normalisation: req_len_i > 32 is clamped to 32. In quad mode, req_len_i[1:0] is ignored (the length is rounded down to a multiple of 4).
- FSM states: IDLE -> CS_SETUP -> CMD -> ADDR -> DUMMY -> DATA -> CS_HOLD -> DONE -> CS_GAP -> IDLE.
  - ADDR is skipped if req_addr_en_i=0.
  - DUMMY is skipped if req_dummy_i=0.
  - DATA is skipped if the normalised length is 0.
- CS_SETUP: csn=0, sclk=0 for CLK_DIV cycles.
- Bit cells: each sclk cycle is CLK_DIV clk_i cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - The host updates sdo on entry to the low half.
  - The device samples on the rising edge.
  - The host registers spi_sdi_i on the clk_i edge where sclk goes 1.
- Bit order: MSB first in every phase. In quad mode, sdo[3] carries the nibble MSB.
- Phase lengths in sclk cycles:
  - CMD: 8 (std) or 2 (quad).
  - ADDR: 32 or 8.
  - DUMMY: req_dummy_i, with sdo=0 and oe=0.
  - DATA: len (std) or len/4 (quad).
- Output enables: oe=0001 (std) or 1111 (quad) during CMD, ADDR and write DATA. oe=0000 during DUMMY, read DATA and idle.
- Read DATA: the shift register clears at acceptance and shifts left by 1 or 4 per sampled cell. The result is right-justified in len bits.
- CS_HOLD: after the final high half, sclk=0 and csn=0 for CLK_DIV cycles.
- DONE: one cycle with csn=1, rsp_valid_o=1 and rsp_rdata_o updated.
  - Reads load the sampled data.
  - Writes load 0.
- CS_GAP: csn=1, ready=0 for CLK_DIV cycles. This guarantees a minimum deselect time.
- Total csn-low time is CLK_DIV*(2 + 2*N), where N is the total sclk cycle count.
- rsp_rdata_o holds its value until the next DONE.

Test Plan:
- Reset: hold rst_ni=0 -> csn=1, sclk=0, oe=0, ready=1. Pulse rst_ni low mid-ADDR -> outputs return to reset values on the same edge, with no rsp_valid.
- Std write, CLK_DIV=2, cmd=0x01, no addr, dummy=0, len=8, wdata=0x01 -> 16 rising sclk edges with sdi0 bits 00000001_00000001. csn low for exactly 68 clk_i cycles. One rsp_valid pulse with rdata=0. The device then reports spi_mode==2.
- Quad read, cmd=0x0B, addr=0x1A10_2000, dummy=8, len=32; the device drives nibbles D,E,A,D,B,E,E,F -> 26 sclk cycles. oe=1111 for the first 10 cycles, then 0000. rdata=0xDEADBEEF.
- Quad write, len=30 -> treated as len 28. 7 data nibbles taken from wdata[27:0], MSB nibble first.
- Back-to-back: req_valid_i held high with two requests -> the second is accepted only after CS_GAP. csn stays high for at least CLK_DIV+1 cycles between frames.
- CLK_DIV=1, std read len=0 with addr_en=0 -> only CMD is sent (8 sclk cycles). rsp_valid fires with rdata=0. sclk period is 2 clk_i cycles.

Source files
------------

// File: rtl/qspi_host_ctrl.sv
// Host-side SPI/QSPI master: serializes one request as command/address/dummy/data
// phases over 1 or 4 lanes (SPI mode 0), with CS setup/hold/gap timing from CLK_DIV.
module qspi_host_ctrl #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_quad_i,
  input  logic [7:0]  req_cmd_i,
  input  logic        req_addr_en_i,
  input  logic [31:0] req_addr_i,
  input  logic [4:0]  req_dummy_i,
  input  logic        req_wr_i,
  input  logic [5:0]  req_len_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        spi_sclk_o,
  output logic        spi_csn_o,
  output logic [3:0]  spi_sdo_o,
  output logic [3:0]  spi_sdo_oe_o,
  input  logic [3:0]  spi_sdi_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD, S_DONE, S_CS_GAP
  } state_e;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        csn_q, csn_d;
  logic [3:0]  sdo_q, sdo_d;
  logic [3:0]  oe_q, oe_d;
  logic [5:0]  cells_q, cells_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        quad_q, quad_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        addr_en_q, addr_en_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  dummy_q, dummy_d;
  logic        wr_q, wr_d;
  logic [5:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;

  logic [5:0]  len_clamp, len_norm;
  logic [3:0]  drive_mask;
  state_e      after_cmd, after_addr, after_dummy, enter_st;
  logic        enter, shift_cell;
  logic [5:0]  ph_cells;
  logic [31:0] ph_data;
  logic [3:0]  ph_oe;

  assign len_clamp   = (req_len_i > 6'd32) ? 6'd32 : req_len_i;
  assign len_norm    = req_quad_i ? {len_clamp[5:2], 2'b00} : len_clamp;
  assign drive_mask  = quad_q ? 4'hF : 4'h1;
  assign after_dummy = (len_q != '0) ? S_DATA : S_CS_HOLD;
  assign after_addr  = (dummy_q != '0) ? S_DUMMY : after_dummy;
  assign after_cmd   = addr_en_q ? S_ADDR : after_addr;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    csn_d       = csn_q;
    sdo_d       = sdo_q;
    oe_d        = oe_q;
    cells_d     = cells_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    quad_d      = quad_q;
    cmd_d       = cmd_q;
    addr_en_d   = addr_en_q;
    addr_d      = addr_q;
    dummy_d     = dummy_q;
    wr_d        = wr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    enter       = 1'b0;
    enter_st    = S_CS_HOLD;
    shift_cell  = 1'b0;
    ph_cells    = '0;
    ph_data     = '0;
    ph_oe       = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          quad_d    = req_quad_i;
          cmd_d     = req_cmd_i;
          addr_en_d = req_addr_en_i;
          addr_d    = req_addr_i;
          dummy_d   = req_dummy_i;
          wr_d      = req_wr_i;
          len_d     = len_norm;
          wdata_d   = req_wdata_i;
          rx_d      = '0;
          csn_d     = 1'b0;
          div_d     = DIV_M1;
          state_d   = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (div_q == '0) begin
          enter    = 1'b1;
          enter_st = S_CMD;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (div_q != '0) begin
          div_d = div_q - 8'd1;
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          div_d  = DIV_M1;
          if (state_q == S_DATA && !wr_q)
            rx_d = quad_q ? {rx_q[27:0], spi_sdi_i} : {rx_q[30:0], spi_sdi_i[0]};
        end else if (cells_q != '0) begin
          sclk_d     = 1'b0;
          div_d      = DIV_M1;
          cells_d    = cells_q - 6'd1;
          shift_cell = 1'b1;
        end else begin
          enter = 1'b1;
          case (state_q)
            S_CMD:   enter_st = after_cmd;
            S_ADDR:  enter_st = after_addr;
            S_DUMMY: enter_st = after_dummy;
            default: enter_st = S_CS_HOLD;
          endcase
        end
      end
      S_CS_HOLD: begin
        if (div_q == '0) begin
          csn_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = wr_q ? '0 : rx_q;
          state_d     = S_DONE;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_DONE: begin
        div_d   = DIV_M1;
        state_d = S_CS_GAP;
      end
      S_CS_GAP: begin
        if (div_q == '0) state_d = S_IDLE;
        else             div_d   = div_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Phase entry loads the phase word MSB-aligned so every phase shares one shifter.
    if (enter) begin
      state_d = enter_st;
      div_d   = DIV_M1;
      sclk_d  = 1'b0;
      case (enter_st)
        S_CMD: begin
          ph_cells = quad_q ? 6'd2 : 6'd8;
          ph_data  = {cmd_q, 24'h0};
          ph_oe    = drive_mask;
        end
        S_ADDR: begin
          ph_cells = quad_q ? 6'd8 : 6'd32;
          ph_data  = addr_q;
          ph_oe    = drive_mask;
        end
        S_DUMMY: begin
          ph_cells = {1'b0, dummy_q};
        end
        S_DATA: begin
          ph_cells = quad_q ? {2'b00, len_q[5:2]} : len_q;
          ph_data  = wr_q ? (wdata_q << (6'd32 - len_q)) : '0;
          ph_oe    = wr_q ? drive_mask : 4'h0;
        end
        default: ;
      endcase
      cells_d = ph_cells - 6'd1;
      tx_d    = ph_data;
      oe_d    = ph_oe;
      if (enter_st == S_CS_HOLD) sdo_d = '0;
      else                       shift_cell = 1'b1;
    end

    if (shift_cell) begin
      sdo_d = quad_q ? tx_d[31:28] : {3'b000, tx_d[31]};
      tx_d  = quad_q ? {tx_d[27:0], 4'h0} : {tx_d[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      sclk_q      <= 1'b0;
      csn_q       <= 1'b1;
      sdo_q       <= '0;
      oe_q        <= '0;
      cells_q     <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      quad_q      <= 1'b0;
      cmd_q       <= '0;
      addr_en_q   <= 1'b0;
      addr_q      <= '0;
      dummy_q     <= '0;
      wr_q        <= 1'b0;
      len_q       <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      csn_q       <= csn_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
      cells_q     <= cells_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      quad_q      <= quad_d;
      cmd_q       <= cmd_d;
      addr_en_q   <= addr_en_d;
      addr_q      <= addr_d;
      dummy_q     <= dummy_d;
      wr_q        <= wr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rdata_q;
  assign spi_sclk_o   = sclk_q;
  assign spi_csn_o    = csn_q;
  assign spi_sdo_o    = sdo_q;
  assign spi_sdo_oe_o = oe_q;

endmodule

// File: tb/tb_qspi_host_ctrl.sv
// Directed bench for qspi_host_ctrl: a vector table of whole transactions checked
// by a bus monitor and a simple device model, plus reset-abort, back-to-back and CLK_DIV=1 cases.
module tb_qspi_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid1;
  logic        req_ready, req_ready1;
  logic        req_quad;
  logic [7:0]  req_cmd;
  logic        req_addr_en;
  logic [31:0] req_addr;
  logic [4:0]  req_dummy;
  logic        req_wr;
  logic [5:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_valid1;
  logic [31:0] rdata, rdata1;
  logic        busy, busy1;
  logic        sclk, sclk1, csn, csn1;
  logic [3:0]  sdo, sdo1, oe, oe1;
  logic [3:0]  dev_sdi;

  always #5 clk = ~clk;

  qspi_host_ctrl #(.CLK_DIV(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_quad_i(req_quad), .req_cmd_i(req_cmd), .req_addr_en_i(req_addr_en),
    .req_addr_i(req_addr), .req_dummy_i(req_dummy), .req_wr_i(req_wr),
    .req_len_i(req_len), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rdata), .busy_o(busy), .spi_sclk_o(sclk), .spi_csn_o(csn),
    .spi_sdo_o(sdo), .spi_sdo_oe_o(oe), .spi_sdi_i(dev_sdi)
  );

  qspi_host_ctrl #(.CLK_DIV(1)) u_div1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_quad_i(req_quad), .req_cmd_i(req_cmd), .req_addr_en_i(req_addr_en),
    .req_addr_i(req_addr), .req_dummy_i(req_dummy), .req_wr_i(req_wr),
    .req_len_i(req_len), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid1),
    .rsp_rdata_o(rdata1), .busy_o(busy1), .spi_sclk_o(sclk1), .spi_csn_o(csn1),
    .spi_sdo_o(sdo1), .spi_sdo_oe_o(oe1), .spi_sdi_i(4'hF)
  );

  typedef struct {
    logic        quad;
    logic [7:0]  cmd;
    logic        addr_en;
    logic [31:0] addr;
    logic [4:0]  dummy;
    logic        wr;
    logic [5:0]  len;
    logic [31:0] wdata;
    logic [31:0] pat;       // data the device drives during DATA
    int          d_start;   // sclk cell index where DATA begins
    int          d_cells;
    int          exp_rises;
    int          exp_csn;
    logic [31:0] exp_rdata;
    logic [127:0] exp_hist;
    int          exp_oe_cells;
    logic [3:0]  exp_oe;
  } vec_t;

  vec_t vecs[7];

  int n_vec = 0;
  int n_bad = 0;

  // Device model state driven by the test sequence
  logic        cur_quad = 1'b0;
  logic [31:0] cur_pat = '0;
  int          cur_start = 0;
  int          cur_d = 0;

  // Monitor state
  logic         prev_csn = 1'b1, prev_sclk = 1'b0;
  int           frames = 0, high_run = 0, last_gap = 0;
  int           csn_low = 0, rise_cnt = 0, oe_cells = 0, rsp_cnt = 0;
  logic [127:0] hist = '0;
  logic [3:0]   oe_acc = '0;
  logic [31:0]  rsp_data = '0;

  always_comb begin
    int j;
    dev_sdi = '0;
    j = rise_cnt - cur_start;
    if (j >= 0 && j < cur_d) begin
      if (cur_quad) dev_sdi = 4'(cur_pat >> (4 * (cur_d - 1 - j)));
      else          dev_sdi = {3'b000, 1'(cur_pat >> (cur_d - 1 - j))};
    end
  end

  always @(negedge clk) begin
    if (prev_csn && !csn) begin
      frames   <= frames + 1;
      last_gap <= high_run;
      high_run <= 0;
      csn_low  <= 1;
      rise_cnt <= 0;
      hist     <= '0;
      oe_cells <= 0;
      oe_acc   <= '0;
      rsp_cnt  <= 0;
    end else begin
      if (!csn) csn_low  <= csn_low + 1;
      else      high_run <= high_run + 1;
      if (sclk && !prev_sclk) begin
        rise_cnt <= rise_cnt + 1;
        hist     <= cur_quad ? {hist[123:0], sdo} : {hist[126:0], sdo[0]};
        if (oe != '0) oe_cells <= oe_cells + 1;
        oe_acc   <= oe_acc | oe;
      end
      if (rsp_valid) begin
        rsp_cnt  <= rsp_cnt + 1;
        rsp_data <= rdata;
      end
    end
    prev_csn  <= csn;
    prev_sclk <= sclk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_req(input vec_t v);
    @(negedge clk);
    req_quad = v.quad; req_cmd = v.cmd; req_addr_en = v.addr_en; req_addr = v.addr;
    req_dummy = v.dummy; req_wr = v.wr; req_len = v.len; req_wdata = v.wdata;
    cur_quad = v.quad; cur_pat = v.pat; cur_start = v.d_start; cur_d = v.d_cells;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic done = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (rsp_cnt != 0 && req_ready) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 128'(done), 128'd1);
  endtask

  initial begin
    vec_t  b2b;
    logic  hit;
    int    rises1, csnl1, rsp1, t_first, t_second, cyc;
    logic  [31:0] rd1;
    logic  [7:0]  bits1;
    logic  prev_s1;

    //          quad cmd    aen addr          dum  wr len    wdata          pat            ds  dc  rises csn  rdata          hist                                    oec oe
    vecs[0] = '{1'b0, 8'h01, 1'b0, 32'h0,        5'd0, 1'b1, 6'd8,  32'h00000001, 32'h000000FF, 8,  8,  16,  68,  32'h0,         128'h0101,                              16, 4'h1};
    vecs[1] = '{1'b1, 8'h0B, 1'b1, 32'h1A102000, 5'd8, 1'b0, 6'd32, 32'h0,        32'hDEADBEEF, 18, 8,  26,  108, 32'hDEADBEEF,  128'h0B1A102000_0000000000000000,       10, 4'hF};
    vecs[2] = '{1'b1, 8'h38, 1'b0, 32'h0,        5'd0, 1'b1, 6'd30, 32'hA5C396E7, 32'hFFFFFFFF, 2,  7,  9,   40,  32'h0,         128'h385C396E7,                         9,  4'hF};
    vecs[3] = '{1'b0, 8'h03, 1'b1, 32'h00000080, 5'd0, 1'b0, 6'd12, 32'h0,        32'h00000ABC, 40, 12, 52,  212, 32'h00000ABC,  128'h0300000080000,                     40, 4'h1};
    vecs[4] = '{1'b0, 8'h9F, 1'b0, 32'h0,        5'd3, 1'b0, 6'd33, 32'h0,        32'h12345678, 11, 32, 43,  176, 32'h12345678,  128'h4F800000000,                       8,  4'h1};
    vecs[5] = '{1'b0, 8'hA5, 1'b1, 32'hFFFFFFFF, 5'd0, 1'b1, 6'd0,  32'h00001234, 32'h0,        40, 0,  40,  164, 32'h0,         128'hA5FFFFFFFF,                        40, 4'h1};
    vecs[6] = '{1'b1, 8'h6B, 1'b0, 32'h0,        5'd0, 1'b0, 6'd7,  32'h0,        32'h00000009, 2,  1,  3,   16,  32'h00000009,  128'h6B0,                               2,  4'hF};

    rst_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
    req_quad = 1'b0; req_cmd = '0; req_addr_en = 1'b0; req_addr = '0;
    req_dummy = '0; req_wr = 1'b0; req_len = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 128'(req_ready), 128'd1);
    chk("rst_busy",  128'(busy),      128'd0);
    chk("rst_rsp",   128'(rsp_valid), 128'd0);
    chk("rst_rdata", 128'(rdata),     128'd0);
    chk("rst_sclk",  128'(sclk),      128'd0);
    chk("rst_csn",   128'(csn),       128'd1);
    chk("rst_sdo",   128'(sdo),       128'd0);
    chk("rst_oe",    128'(oe),        128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_req(vecs[i]);
      wait_done($sformatf("v%0d_done", i));
      chk($sformatf("v%0d_rises", i), 128'(rise_cnt), 128'(vecs[i].exp_rises));
      chk($sformatf("v%0d_csn_low", i), 128'(csn_low), 128'(vecs[i].exp_csn));
      chk($sformatf("v%0d_rsp_cnt", i), 128'(rsp_cnt), 128'd1);
      chk($sformatf("v%0d_rdata", i), 128'(rsp_data), 128'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_sdo_bits", i), hist, vecs[i].exp_hist);
      chk($sformatf("v%0d_oe_cells", i), 128'(oe_cells), 128'(vecs[i].exp_oe_cells));
      chk($sformatf("v%0d_oe_mask", i), 128'(oe_acc), 128'(vecs[i].exp_oe));
    end

    // Asynchronous reset in the middle of the address phase
    start_req(vecs[3]);
    hit = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (rise_cnt == 12) begin hit = 1'b1; break; end
    end
    chk("abort_reach_addr", 128'(hit), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_csn",   128'(csn),       128'd1);
    chk("abort_sclk",  128'(sclk),      128'd0);
    chk("abort_oe",    128'(oe),        128'd0);
    chk("abort_sdo",   128'(sdo),       128'd0);
    chk("abort_busy",  128'(busy),      128'd0);
    chk("abort_ready", 128'(req_ready), 128'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("abort_no_rsp", 128'(rsp_cnt), 128'd0);
    chk("abort_rdata",  128'(rdata),   128'd0);

    // Back-to-back: valid held high across two frames
    b2b = vecs[0];
    @(negedge clk);
    req_quad = b2b.quad; req_cmd = b2b.cmd; req_addr_en = b2b.addr_en; req_addr = b2b.addr;
    req_dummy = b2b.dummy; req_wr = b2b.wr; req_len = b2b.len; req_wdata = b2b.wdata;
    cur_quad = b2b.quad; cur_pat = b2b.pat; cur_start = b2b.d_start; cur_d = b2b.d_cells;
    cyc = frames;
    req_valid = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (frames == cyc + 2) begin hit = 1'b1; break; end
    end
    req_valid = 1'b0;
    chk("b2b_second_frame", 128'(hit), 128'd1);
    chk("b2b_csn_gap", 128'(last_gap), 128'd4);
    wait_done("b2b_done");
    chk("b2b_csn_low", 128'(csn_low), 128'd68);
    chk("b2b_rsp_cnt", 128'(rsp_cnt), 128'd1);

    // CLK_DIV=1 instance: std read, len 0, no address
    @(negedge clk);
    req_quad = 1'b0; req_cmd = 8'h5A; req_addr_en = 1'b0; req_addr = '0;
    req_dummy = '0; req_wr = 1'b0; req_len = '0; req_wdata = '0;
    req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    rises1 = 0; csnl1 = 0; rsp1 = 0; rd1 = 32'hFFFFFFFF; bits1 = '0;
    t_first = -1; t_second = -1; prev_s1 = 1'b0;
    if (!csn1) csnl1 = 1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk); #1;
      if (!csn1) csnl1++;
      if (sclk1 && !prev_s1) begin
        rises1++;
        bits1 = {bits1[6:0], sdo1[0]};
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
      if (rsp_valid1) begin rsp1++; rd1 = rdata1; end
      prev_s1 = sclk1;
    end
    chk("div1_rises",   128'(rises1),             128'd8);
    chk("div1_csn_low", 128'(csnl1),              128'd18);
    chk("div1_rsp",     128'(rsp1),               128'd1);
    chk("div1_rdata",   128'(rd1),                128'd0);
    chk("div1_period",  128'(t_second - t_first), 128'd2);
    chk("div1_cmd",     128'(bits1),              128'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
